// File: rtl/alu_pkg.sv
// Shared ALU writeback definitions: opcodes, SREG bit positions, FSM states,
// and the per-opcode flag-update mask.
package alu_pkg;
  localparam logic [3:0] FSL_ADD  = 4'b0000;
  localparam logic [3:0] FSL_SUB  = 4'b0001;
  localparam logic [3:0] FSL_ADDC = 4'b0010;
  localparam logic [3:0] FSL_SUBC = 4'b0011;
  localparam logic [3:0] FSL_XOR  = 4'b0100;
  localparam logic [3:0] FSL_AND  = 4'b0101;
  localparam logic [3:0] FSL_OR   = 4'b0110;
  localparam logic [3:0] FSL_NAND = 4'b0111;
  localparam logic [3:0] FSL_LSL  = 4'b1000;
  localparam logic [3:0] FSL_LSR  = 4'b1001;
  localparam logic [3:0] FSL_ASR  = 4'b1010;
  localparam logic [3:0] FSL_ASL  = 4'b1011;
  localparam logic [3:0] FSL_ROL  = 4'b1100;
  localparam logic [3:0] FSL_ROR  = 4'b1101;
  localparam logic [3:0] FSL_MUL  = 4'b1110;
  localparam logic [3:0] FSL_CMP  = 4'b1111;

  localparam int SREG_Z = 0;
  localparam int SREG_C = 1;
  localparam int SREG_S = 2;
  localparam int SREG_V = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WR_LO, ST_WR_HI} wb_state_e;

  // Mask bit set = flag taken from the op, clear = committed flag held.
  function automatic logic [3:0] flag_mask(input logic [3:0] fsl);
    logic [3:0] m;
    m = 4'b0000;
    case (fsl)
      FSL_ADD, FSL_SUB, FSL_ADDC, FSL_SUBC, FSL_CMP:  m = 4'b1111;
      FSL_XOR, FSL_AND, FSL_OR, FSL_NAND,
      FSL_ROL, FSL_ROR, FSL_MUL:                      m = 4'b0101;
      FSL_LSL, FSL_LSR, FSL_ASR, FSL_ASL:             m = 4'b0111;
      default:                                        m = 4'b0000;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-to-writeback bus plus register-file/SREG outputs.
// WB_FWD_EN adds the fwd_* forwarding copy of the write port.
interface alu_writeback_stage_if #(parameter int DATA_W = 8, parameter int ADDR_W = 3);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_fsl;
  logic [ADDR_W-1:0] in_dst;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_mul_high;
  logic [3:0]        in_sreg;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        sreg;
  logic              carry_fb;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  modport master (
    output in_valid, in_fsl, in_dst, in_result, in_mul_high, in_sreg,
    input  in_ready, rf_we, rf_waddr, rf_wdata, sreg, carry_fb
`ifdef WB_FWD_EN
    , input fwd_valid, fwd_addr, fwd_data
`endif
  );

  modport slave (
    input  in_valid, in_fsl, in_dst, in_result, in_mul_high, in_sreg,
    output in_ready, rf_we, rf_waddr, rf_wdata, sreg, carry_fb
`ifdef WB_FWD_EN
    , output fwd_valid, fwd_addr, fwd_data
`endif
  );
endinterface

// File: rtl/alu_writeback_stage_sreg_merge.sv
// Merges an op's flags into the committed SREG; MULTIPLY derives Z/S from
// the full 16-bit product rather than the ALU flags.
module sreg_merge import alu_pkg::*; #(parameter int DATA_W = 8) (
  input  logic [3:0]        old_sreg,
  input  logic [3:0]        alu_sreg,
  input  logic [3:0]        fsl,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] mul_high,
  output logic [3:0]        new_sreg
);
  logic [3:0] src;
  logic [3:0] mask;

  always_comb begin
    src  = alu_sreg;
    mask = flag_mask(fsl);
    if (fsl == FSL_MUL) begin
      src[SREG_Z] = (result == '0) && (mul_high == '0);
      src[SREG_S] = mul_high[DATA_W-1];
    end
    new_sreg = (src & mask) | (old_sreg & ~mask);
  end
endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: commits results to the register file (MULTIPLY as two
// writes) and updates SREG. WB_FWD_EN adds forwarding outputs and C bypass.
module alu_writeback_stage import alu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  alu_writeback_stage_if.slave wb
);
  wb_state_e         state;
  logic [3:0]        h_fsl, h_sreg;
  logic [ADDR_W-1:0] h_dst;
  logic [DATA_W-1:0] h_result, h_high;
  logic [3:0]        sreg_q, sreg_nxt, h_mask;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              accept, in_ready;

  assign in_ready = (state != ST_WR_LO) || (h_fsl != FSL_MUL);
  assign accept   = wb.in_valid && in_ready;
  assign h_mask   = flag_mask(h_fsl);

  sreg_merge #(.DATA_W(DATA_W)) u_merge (
    .old_sreg (sreg_q),
    .alu_sreg (h_sreg),
    .fsl      (h_fsl),
    .result   (h_result),
    .mul_high (h_high),
    .new_sreg (sreg_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      h_fsl      <= '0;
      h_sreg     <= '0;
      h_dst      <= '0;
      h_result   <= '0;
      h_high     <= '0;
      sreg_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (accept) begin
        h_fsl    <= wb.in_fsl;
        h_sreg   <= wb.in_sreg;
        h_dst    <= wb.in_dst;
        h_result <= wb.in_result;
        h_high   <= wb.in_mul_high;
      end
      if (state == ST_WR_LO) sreg_q <= sreg_nxt;
      // MULTIPLY's high byte always goes out the cycle after the low byte
      if (state == ST_WR_LO && h_fsl == FSL_MUL) begin
        state      <= ST_WR_HI;
        rf_we_q    <= 1'b1;
        rf_waddr_q <= h_dst + 1'b1;
        rf_wdata_q <= h_high;
      end else if (accept) begin
        state      <= ST_WR_LO;
        rf_we_q    <= (wb.in_fsl != FSL_CMP);
        rf_waddr_q <= wb.in_dst;
        rf_wdata_q <= wb.in_result;
      end else begin
        state   <= ST_IDLE;
        rf_we_q <= 1'b0;
      end
    end
  end

  assign wb.in_ready = in_ready;
  assign wb.rf_we    = rf_we_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;
  assign wb.sreg     = sreg_q;

`ifdef WB_FWD_EN
  assign wb.fwd_valid = rf_we_q;
  assign wb.fwd_addr  = rf_waddr_q;
  assign wb.fwd_data  = rf_wdata_q;
  assign wb.carry_fb  = (state == ST_WR_LO && h_mask[SREG_C]) ? sreg_nxt[SREG_C]
                                                              : sreg_q[SREG_C];
`else
  assign wb.carry_fb  = sreg_q[SREG_C];
`endif
endmodule
